depth_frame_ctrl: RTL and testbench
===================================

// Module: depth_frame_ctrl
// PURPOSE
//  Sequencer in front of depth_buffer: owns its config (test/write enable, func, clear value).
//  Serialises host commands (CONFIG, CLEAR, FLUSH) against the fragment stream.
//  Before a clear, gates new fragments and drains the 3-stage depth pipeline,
//  so no late stage-2 write can land after or during a clear.
// PARAMETERS
//  PIPE_DEPTH   3   pipeline-advance cycles needed to retire every fragment behind the gate
//  CNT_W        32  width of perf counters (used only with DEPTH_CTRL_PERF_EN)
// PORTS
//  clk                 in   1   single clock
//  rst                 in   1   reset; asynchronous, active-high
//  cmd_valid           in   1   host command valid
//  cmd_ready           out  1   command accepted on cmd_valid&&cmd_ready
//  cmd_op              in   2   depth_cmd_op_t: NOP/CONFIG/CLEAR/FLUSH
//  cmd_cfg             in   6   depth_cfg_t {test_en, write_en, depth_func_t func[3:0]}
//  cmd_clear_value     in   16  clear value, latched with CLEAR
//  op_done             out  1   1-cycle pulse when CLEAR or FLUSH completes
//  busy                out  1   state != IDLE
//  up_valid/up_ready   in/out 1 fragment stream from texture_unit
//  dn_valid/dn_ready   out/in 1 fragment stream to depth_buffer frag_in_valid/ready
//  db_out_valid        in   1   monitor of depth_buffer frag_out_valid
//  db_out_ready        in   1   monitor of depth_buffer frag_out_ready
//  db_test_en, db_write_en  out  1   to depth_buffer
//  db_func             out  4   depth_func_t to depth_buffer
//  db_clear            out  1   clear pulse to depth_buffer
//  db_clear_value      out  16  to depth_buffer
//  db_clearing         in   1   depth_buffer depth_clearing
// BEHAVIOUR
//  Reset: state=IDLE, cmd_ready=0 until first post-reset cycle, op_done=0, busy=0, db_clear=0,
//   db_test_en=0, db_write_en=0, db_func=GR_CMP_LESS, db_clear_value=16'hFFFF.
//  gate_open = (state==IDLE) && !db_clearing. dn_valid=up_valid&&gate_open; up_ready=dn_ready&&gate_open
//   (combinational pass-through, no added latency).
//  advance = !(db_out_valid && !db_out_ready).
//  States:
//   IDLE: cmd_ready = !db_clearing.
//    - CONFIG: cfg regs load at that edge; no drain; stay IDLE. In-flight fragments keep their
//      own config (depth_buffer pipelines it).
//    - CLEAR/FLUSH: latch op and clear value; drain_cnt<=PIPE_DEPTH; ->DRAIN.
//    - NOP: accepted, ignored.
//   DRAIN: cmd_ready=0, gate closed; drain_cnt decrements on each advance cycle.
//    - At 0: CLEAR ->CLR_REQ; FLUSH ->IDLE with op_done=1.
//   CLR_REQ: db_clear=1 for exactly 1 cycle; seen<=0; ->CLR_WAIT.
//   CLR_WAIT: seen<=1 once db_clearing=1. When seen && !db_clearing: ->IDLE, op_done=1.
//  Boundary cases:
//   - Fragment handshake in the same cycle a CLEAR is accepted completes; PIPE_DEPTH covers it.
//   - Downstream stall in DRAIN freezes drain_cnt; no timeout.
//   - db_clear_value is stable from CLR_REQ until IDLE.
//   - Reset mid-DRAIN/CLR_WAIT returns to IDLE; op_done not issued.
//     If db_clearing is still high, gate and cmd_ready stay low until it falls.
//   - drain_cnt width is $clog2(PIPE_DEPTH+1) and saturates at 0.
// CONFIGURATION
//  DEPTH_CTRL_PERF_EN defined: adds outputs perf_clear_cyc[CNT_W] (cycles in CLR_REQ/CLR_WAIT)
//   and perf_frag_cnt[CNT_W] (dn_valid&&dn_ready); both wrap, reset to 0.
//  Undefined: these ports and counters do not exist; behaviour otherwise identical.
// STRUCTURE
//  celery_pkg gains:
//   - depth_cmd_op_t (2b enum: NOP=0, CONFIG=1, CLEAR=2, FLUSH=3)
//   - depth_cfg_t packed struct
//   - DEPTH_PIPE_STAGES=3
//  Reuses existing depth_func_t/GR_CMP_*.
//  Single module: one FSM plus drain counter; no sub-module.
// TESTING
//  1 CONFIG {1,1,GR_CMP_LEQUAL} in IDLE -> cmd_ready=1 same cycle; db_* update next edge; stream uninterrupted.
//  2 CLEAR 0xFFFF while 2 fragments in flight, dn_ready=1 -> gate low next cycle; db_clear after 3 cycles;
//    op_done when db_clearing falls.
//  3 CLEAR with db_out_ready held 0 for 5 cycles during DRAIN -> db_clear delayed by exactly 5 cycles;
//    no fragment crosses gate.
//  4 FLUSH -> op_done 3 advance cycles after accept; db_clear never asserts.
//  5 rst pulse in CLR_WAIT with model db_clearing high -> outputs reset; up_ready=0 until db_clearing=0;
//    no op_done.
//  6 (PERF_EN) 10 fragments then CLEAR on 16x16 model (256-cycle clear) -> perf_frag_cnt=10;
//    perf_clear_cyc=clear length+handshake overhead.

Source files
------------

// File: rtl/celery_pkg.sv
// Shared depth-path types: compare functions, host command ops and the depth config word.
package celery_pkg;

    typedef enum logic [3:0] {
        GR_CMP_NEVER    = 4'd0,
        GR_CMP_LESS     = 4'd1,
        GR_CMP_EQUAL    = 4'd2,
        GR_CMP_LEQUAL   = 4'd3,
        GR_CMP_GREATER  = 4'd4,
        GR_CMP_NOTEQUAL = 4'd5,
        GR_CMP_GEQUAL   = 4'd6,
        GR_CMP_ALWAYS   = 4'd7
    } depth_func_t;

    typedef enum logic [1:0] {
        CMD_NOP    = 2'd0,
        CMD_CONFIG = 2'd1,
        CMD_CLEAR  = 2'd2,
        CMD_FLUSH  = 2'd3
    } depth_cmd_op_t;

    typedef struct packed {
        logic        test_en;
        logic        write_en;
        depth_func_t func;
    } depth_cfg_t;

    localparam int          DEPTH_PIPE_STAGES = 3;
    localparam depth_cfg_t  DEPTH_CFG_RESET   = '{test_en: 1'b0, write_en: 1'b0, func: GR_CMP_LESS};
    localparam logic [15:0] DEPTH_CLEAR_RESET = 16'hFFFF;

endpackage

// File: rtl/depth_frame_ctrl.sv
// Sequencer in front of depth_buffer: owns its config and serialises CONFIG/CLEAR/FLUSH
// against the fragment stream. Optional perf counters with DEPTH_CTRL_PERF_EN.
//
// state     | meaning
// IDLE      | gate open (unless depth_buffer clearing), accepting commands
// DRAIN     | gate closed, retiring PIPE_DEPTH advance cycles of in-flight fragments
// CLR_REQ   | one-cycle db_clear pulse
// CLR_WAIT  | waiting for db_clearing to rise and then fall
module depth_frame_ctrl
    import celery_pkg::*;
#(
    parameter int PIPE_DEPTH = DEPTH_PIPE_STAGES
`ifdef DEPTH_CTRL_PERF_EN
    , parameter int CNT_W    = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  depth_cmd_op_t       cmd_op,
    input  depth_cfg_t          cmd_cfg,
    input  logic [15:0]         cmd_clear_value,
    output logic                op_done,
    output logic                busy,
    input  logic                up_valid,
    output logic                up_ready,
    output logic                dn_valid,
    input  logic                dn_ready,
    input  logic                db_out_valid,
    input  logic                db_out_ready,
    output logic                db_test_en,
    output logic                db_write_en,
    output depth_func_t         db_func,
    output logic                db_clear,
    output logic [15:0]         db_clear_value,
    input  logic                db_clearing
`ifdef DEPTH_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]    perf_clear_cyc,
    output logic [CNT_W-1:0]    perf_frag_cnt
`endif
);

    localparam int            DW         = $clog2(PIPE_DEPTH + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_CLR_REQ  = 2'd2,
        ST_CLR_WAIT = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d, drain_step;
    logic         is_clear_q, is_clear_d;
    logic         seen_q, seen_d;
    logic         started_q;
    depth_cfg_t   cfg_q, cfg_d;
    logic [15:0]  clr_val_q, clr_val_d;
    logic         op_done_q, op_done_d;
    logic         db_clear_q, db_clear_d;

    logic gate_open;
    logic advance;
    logic cmd_fire;

    assign gate_open = (state_q == ST_IDLE) && !db_clearing;
    assign advance   = !(db_out_valid && !db_out_ready);
    // started_q keeps cmd_ready low through the cycle reset is released
    assign cmd_ready = gate_open && started_q;
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign dn_valid  = up_valid && gate_open;
    assign up_ready  = dn_ready && gate_open;
    assign busy      = (state_q != ST_IDLE);

    assign op_done        = op_done_q;
    assign db_clear       = db_clear_q;
    assign db_test_en     = cfg_q.test_en;
    assign db_write_en    = cfg_q.write_en;
    assign db_func        = cfg_q.func;
    assign db_clear_value = clr_val_q;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        drain_step  = drain_cnt_q;
        is_clear_d  = is_clear_q;
        seen_d      = seen_q;
        cfg_d       = cfg_q;
        clr_val_d   = clr_val_q;
        op_done_d   = 1'b0;
        db_clear_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        CMD_CONFIG: cfg_d = cmd_cfg;
                        CMD_CLEAR, CMD_FLUSH: begin
                            is_clear_d  = (cmd_op == CMD_CLEAR);
                            if (cmd_op == CMD_CLEAR) begin
                                clr_val_d = cmd_clear_value;
                            end
                            drain_cnt_d = DRAIN_INIT;
                            state_d     = ST_DRAIN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_DRAIN: begin
                if (advance && (drain_cnt_q != '0)) begin
                    drain_step = drain_cnt_q - DW'(1);
                end
                drain_cnt_d = drain_step;
                if (drain_step == '0) begin
                    if (is_clear_q) begin
                        state_d    = ST_CLR_REQ;
                        db_clear_d = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        op_done_d = 1'b1;
                    end
                end
            end
            ST_CLR_REQ: begin
                seen_d  = 1'b0;
                state_d = ST_CLR_WAIT;
            end
            ST_CLR_WAIT: begin
                if (db_clearing) begin
                    seen_d = 1'b1;
                end
                if (seen_q && !db_clearing) begin
                    state_d   = ST_IDLE;
                    op_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            is_clear_q  <= 1'b0;
            seen_q      <= 1'b0;
            started_q   <= 1'b0;
            cfg_q       <= DEPTH_CFG_RESET;
            clr_val_q   <= DEPTH_CLEAR_RESET;
            op_done_q   <= 1'b0;
            db_clear_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            is_clear_q  <= is_clear_d;
            seen_q      <= seen_d;
            started_q   <= 1'b1;
            cfg_q       <= cfg_d;
            clr_val_q   <= clr_val_d;
            op_done_q   <= op_done_d;
            db_clear_q  <= db_clear_d;
        end
    end

`ifdef DEPTH_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_clear_q, perf_clear_d;
    logic [CNT_W-1:0] perf_frag_q, perf_frag_d;

    always_comb begin
        perf_clear_d = perf_clear_q;
        perf_frag_d  = perf_frag_q;
        if ((state_q == ST_CLR_REQ) || (state_q == ST_CLR_WAIT)) begin
            perf_clear_d = perf_clear_q + CNT_W'(1);
        end
        if (dn_valid && dn_ready) begin
            perf_frag_d = perf_frag_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_clear_q <= '0;
            perf_frag_q  <= '0;
        end else begin
            perf_clear_q <= perf_clear_d;
            perf_frag_q  <= perf_frag_d;
        end
    end

    assign perf_clear_cyc = perf_clear_q;
    assign perf_frag_cnt  = perf_frag_q;
`endif

endmodule

// File: tb/tb_depth_frame_ctrl.sv
// Directed bench for depth_frame_ctrl with a small depth_buffer clear model.
module tb_depth_frame_ctrl;
    import celery_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    depth_cmd_op_t cmd_op = CMD_NOP;
    depth_cfg_t    cmd_cfg = '0;
    logic [15:0]   cmd_clear_value = 16'h0;
    logic          op_done, busy;
    logic          up_valid = 1'b0, up_ready;
    logic          dn_valid, dn_ready = 1'b1;
    logic          db_out_valid = 1'b1, db_out_ready = 1'b1;
    logic          db_test_en, db_write_en;
    depth_func_t   db_func;
    logic          db_clear;
    logic [15:0]   db_clear_value;
    logic          db_clearing;
`ifdef DEPTH_CTRL_PERF_EN
    logic [31:0]   perf_clear_cyc, perf_frag_cnt;
`endif

    int   clr_cnt   = 0;
    int   clr_len   = 4;
    logic clr_force = 1'b0;
    int   errors    = 0;
    int   checks    = 0;

    always #5 clk = ~clk;

    // depth_buffer clear model: busy for clr_len cycles after the pulse is sampled
    always @(posedge clk) begin
        if (db_clear) clr_cnt <= clr_len;
        else if (clr_cnt != 0) clr_cnt <= clr_cnt - 1;
    end
    assign db_clearing = (clr_cnt != 0) || clr_force;

    depth_frame_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_cfg(cmd_cfg), .cmd_clear_value(cmd_clear_value),
        .op_done(op_done), .busy(busy),
        .up_valid(up_valid), .up_ready(up_ready),
        .dn_valid(dn_valid), .dn_ready(dn_ready),
        .db_out_valid(db_out_valid), .db_out_ready(db_out_ready),
        .db_test_en(db_test_en), .db_write_en(db_write_en), .db_func(db_func),
        .db_clear(db_clear), .db_clear_value(db_clear_value), .db_clearing(db_clearing)
`ifdef DEPTH_CTRL_PERF_EN
        , .perf_clear_cyc(perf_clear_cyc), .perf_frag_cnt(perf_frag_cnt)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_cmd(input depth_cmd_op_t op, input depth_cfg_t cfg, input logic [15:0] val);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_cfg = cfg;
        cmd_clear_value = val;
        #1;
        check_val("cmd_ready_on_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_op = CMD_NOP;
    endtask

    // cycles after accept until db_clear or op_done; stalls downstream for the first `stall` cycles
    task automatic drain_wait(input int stall, output int n, output int leak, output int clr_seen);
        n = -1;
        leak = 0;
        clr_seen = 0;
        for (int i = 1; i <= 60; i++) begin
            db_out_ready = (i <= stall) ? 1'b0 : 1'b1;
            tick();
            if (db_clear) clr_seen++;
            if (db_clear || op_done) begin
                n = i;
                break;
            end
            if (dn_valid) leak++;
        end
        db_out_ready = 1'b1;
    endtask

    task automatic wait_done(output int n, output int clr_seen);
        n = -1;
        clr_seen = 0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (db_clear) clr_seen++;
            if (op_done) begin
                n = i;
                break;
            end
        end
    endtask

    int n, leak, cs, acc;
    depth_cfg_t cfg_le;

    initial begin
        cfg_le = '{test_en: 1'b1, write_en: 1'b1, func: GR_CMP_LEQUAL};
        @(negedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_cmd_ready", cmd_ready, 0);
        check_val("rst_op_done", op_done, 0);
        check_val("rst_db_clear", db_clear, 0);
        check_val("rst_test_en", db_test_en, 0);
        check_val("rst_write_en", db_write_en, 0);
        check_val("rst_func", db_func, GR_CMP_LESS);
        check_val("rst_clear_value", db_clear_value, 16'hFFFF);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("first_cycle_cmd_ready", cmd_ready, 0);
        tick();
        check_val("cmd_ready_after_reset", cmd_ready, 1);

        // 1: CONFIG in IDLE with a running stream
        up_valid = 1'b1;
        dn_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = CMD_CONFIG;
        cmd_cfg = cfg_le;
        #1;
        check_val("cfg_cmd_ready", cmd_ready, 1);
        check_val("cfg_dn_valid_same", dn_valid, 1);
        check_val("cfg_up_ready_same", up_ready, 1);
        check_val("cfg_func_before_edge", db_func, GR_CMP_LESS);
        tick();
        cmd_valid = 1'b0;
        check_val("cfg_func", db_func, GR_CMP_LEQUAL);
        check_val("cfg_test_en", db_test_en, 1);
        check_val("cfg_write_en", db_write_en, 1);
        check_val("cfg_busy", busy, 0);
        check_val("cfg_dn_valid_after", dn_valid, 1);

        // NOP accepted and ignored
        do_cmd(CMD_NOP, '0, 16'h0);
        check_val("nop_busy", busy, 0);
        check_val("nop_func_kept", db_func, GR_CMP_LEQUAL);

        // 2: CLEAR 0xFFFF with fragments in flight
        do_cmd(CMD_CLEAR, '0, 16'hFFFF);
        check_val("clr2_gate_dn_valid", dn_valid, 0);
        check_val("clr2_gate_up_ready", up_ready, 0);
        check_val("clr2_busy", busy, 1);
        check_val("clr2_cmd_ready", cmd_ready, 0);
        drain_wait(0, n, leak, cs);
        check_val("clr2_drain_cycles", n, 3);
        check_val("clr2_leak", leak, 0);
        check_val("clr2_value", db_clear_value, 16'hFFFF);
        wait_done(n, cs);
        check_val("clr2_done_cycles", n, 6);
        check_val("clr2_db_clear_once", cs, 0);
        check_val("clr2_clearing_low_at_done", db_clearing, 0);
        check_val("clr2_gate_reopen", dn_valid, 1);
        tick();
        check_val("clr2_done_pulse", op_done, 0);

        // 3: CLEAR with a 5-cycle downstream stall during DRAIN
        do_cmd(CMD_CLEAR, '0, 16'h1234);
        drain_wait(5, n, leak, cs);
        check_val("clr3_drain_cycles", n, 8);
        check_val("clr3_leak", leak, 0);
        check_val("clr3_value_at_req", db_clear_value, 16'h1234);
        wait_done(n, cs);
        check_val("clr3_done_cycles", n, 6);
        check_val("clr3_value_at_done", db_clear_value, 16'h1234);

        // 4: FLUSH never pulses db_clear
        do_cmd(CMD_FLUSH, '0, 16'h5555);
        drain_wait(0, n, leak, cs);
        check_val("flush_done_cycles", n, 3);
        check_val("flush_op_done", op_done, 1);
        acc = cs;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (db_clear) acc++;
        end
        check_val("flush_no_db_clear", acc, 0);
        check_val("flush_busy", busy, 0);
        check_val("flush_value_kept", db_clear_value, 16'h1234);

        // 5: reset while in CLR_WAIT with the buffer still clearing
        up_valid = 1'b0;
        do_cmd(CMD_CLEAR, '0, 16'hABCD);
        drain_wait(0, n, leak, cs);
        tick();
        tick();
        check_val("rst5_busy_before", busy, 1);
        clr_force = 1'b1;
        rst = 1'b1;
        #1;
        check_val("rst5_busy", busy, 0);
        check_val("rst5_func", db_func, GR_CMP_LESS);
        check_val("rst5_value", db_clear_value, 16'hFFFF);
        check_val("rst5_up_ready", up_ready, 0);
        check_val("rst5_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (up_ready || cmd_ready || op_done) acc++;
        end
        check_val("rst5_held_while_clearing", acc, 0);
        clr_force = 1'b0;
        #1;
        check_val("rst5_up_ready_after", up_ready, 1);
        check_val("rst5_cmd_ready_after", cmd_ready, 1);

`ifdef DEPTH_CTRL_PERF_EN
        // 6: perf counters over 10 fragments and a 256-cycle clear
        clr_len = 256;
        up_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        up_valid = 1'b0;
        check_val("perf_frag_cnt", perf_frag_cnt, 10);
        do_cmd(CMD_CLEAR, '0, 16'h0000);
        drain_wait(0, n, leak, cs);
        wait_done(n, cs);
        check_val("perf_clear_done", op_done, 1);
        check_val("perf_clear_cyc", perf_clear_cyc, 258);
        check_val("perf_frag_after_clear", perf_frag_cnt, 10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
